// File: rtl/uart_pkg.sv
// Shared UART definitions: default clock/baud, bit-time derivation, FSM state encoding.
package uart_pkg;

   localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
   localparam int unsigned DEF_BAUD_RATE = 9600;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Clock cycles per serial bit (integer division).
   function automatic int unsigned bit_cnt(input int unsigned clk_freq, input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Clock cycles to the middle of a bit.
   function automatic int unsigned half_cnt(input int unsigned clk_freq, input int unsigned baud_rate);
      return bit_cnt(clk_freq, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/rx_uart_if.sv
// Receive-side result bus: received byte plus one-cycle valid / framing-error strobes.
interface rx_uart_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;

   modport master (output rx_data, output rx_valid, output rx_err);
   modport slave  (input  rx_data, input  rx_valid, input  rx_err);
endinterface

// File: rtl/tx_uart.sv
// 8N1 UART transmitter, LSB first; a tx_ready strobe in idle launches one frame.
module tx_uart
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
   parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_ready,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_busy
);

   localparam int unsigned BIT_CNT = bit_cnt(CLK_FREQ, BAUD_RATE);
   localparam int unsigned CNT_W   = $clog2(BIT_CNT);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CNT - 1);

   uart_state_t      state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       idx, idx_n;
   logic [7:0]       shreg, shreg_n;
   logic             tx_n;

   // State, timing and output-line registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         tx    <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shreg <= shreg_n;
         tx    <= tx_n;
      end
   end

   // Frame sequencing; the line level is derived from the next state so tx is registered.
   always_comb begin
      state_n = state;
      cnt_n   = cnt + CNT_W'(1);
      idx_n   = idx;
      shreg_n = shreg;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (tx_ready) begin
               shreg_n = tx_data;
               state_n = START;
            end
         end
         START: begin
            if (cnt == BIT_LAST) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n = '0;
               idx_n = idx + 3'd1;
               if (idx == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shreg_n[idx_n];
         default: tx_n = 1'b1;
      endcase
   end

   assign tx_busy = (state != IDLE);

endmodule

// File: rtl/uart_sync.sv
// 1-bit two-flop synchronizer with a configurable reset value.
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rx_uart.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, LSB-first shift, stop-bit check.
module rx_uart
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
   parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   rx_uart_if.master  bus
);

   localparam int unsigned BIT_CNT  = bit_cnt(CLK_FREQ, BAUD_RATE);
   localparam int unsigned HALF_CNT = half_cnt(CLK_FREQ, BAUD_RATE);
   localparam int unsigned CNT_W    = $clog2(BIT_CNT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

   uart_state_t      state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       idx, idx_n;
   logic [7:0]       shreg, shreg_n;
   logic [7:0]       data_q, data_n;
   logic             valid_q, valid_n;
   logic             err_q, err_n;
   logic             rx_s;
   logic             rx_prev;

   uart_sync #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // FSM, bit timing, shift register, outputs and edge-detect history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rx_prev <= 1'b1;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shreg   <= shreg_n;
         data_q  <= data_n;
         valid_q <= valid_n;
         err_q   <= err_n;
         rx_prev <= rx_s;
      end
   end

   // Next-state logic; only the mid-bit samples in START/DATA/STOP are looked at.
   always_comb begin
      state_n = state;
      cnt_n   = cnt + CNT_W'(1);
      idx_n   = idx;
      shreg_n = shreg;
      data_n  = data_q;
      valid_n = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s && rx_prev) state_n = START;
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_n = '0;
               if (!rx_s) begin
                  idx_n   = '0;
                  state_n = DATA;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n          = '0;
               shreg_n[idx]   = rx_s;
               idx_n          = idx + 3'd1;
               if (idx == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_n   = '0;
               state_n = IDLE;
               if (rx_s) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.rx_data  = data_q;
   assign bus.rx_valid = valid_q;
   assign bus.rx_err   = err_q;

endmodule
